// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the download scheduler.
// Issue FSM encoding and SDRAM byte-mask constants.
package jtframe_dwnld_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] MASK_FULL = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;

endpackage

// File: rtl/jtframe_dwnld_if.sv
// SDRAM programming channel: word request held until a one-cycle ack.
// master = scheduler, slave = SDRAM controller.
interface jtframe_dwnld_if #(
  parameter int AW = 25
);

  logic [AW-2:0] prog_addr;
  logic [15:0]   prog_data;
  logic [1:0]    prog_mask;
  logic          prog_we;
  logic          prog_rdy;

  modport master (
    output prog_addr,
    output prog_data,
    output prog_mask,
    output prog_we,
    input  prog_rdy
  );

  modport slave (
    input  prog_addr,
    input  prog_data,
    input  prog_mask,
    input  prog_we,
    output prog_rdy
  );

endinterface

// File: rtl/jtframe_dwnld_fifo.sv
// Small first-word-fall-through word FIFO.
// A push while full is dropped unless a pop frees a slot that cycle.
module jtframe_dwnld_fifo #(
  parameter int W       = 42,
  parameter int FIFO_AW = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [W-1:0]     mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign wr_ok = push & (~full | pop);
  assign rd_ok = pop & ~empty;
  assign dout  = mem[rd_ptr[FIFO_AW-1:0]];

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[FIFO_AW-1:0]] <= din;
  end

  // read/write pointers with wrap bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/jtframe_dwnld_sched.sv
// ioctl download scheduler: routes bytes, packs ROM bytes to
// 16-bit words, queues them and issues them to SDRAM.
module jtframe_dwnld_sched
  import jtframe_dwnld_pkg::*;
#(
  parameter int AW      = 25,
  parameter int FIFO_AW = 2,
  parameter int NVAW    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [AW-1:0]     ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  input  logic              ioctl_ram,
  input  logic              ioctl_cheat,
  jtframe_dwnld_if.master   prog,
  output logic              cheat_we,
  output logic [7:0]        cheat_addr,
  output logic [7:0]        cheat_din,
  output logic              nvram_we,
  output logic [NVAW-1:0]   nvram_addr,
  output logic [7:0]        nvram_din,
  output logic              busy,
  output logic              overflow
);

  localparam int WA = AW - 1;
  localparam int W  = WA + 16 + 2;

  typedef struct packed {
    logic [WA-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } word_t;

  logic          rom_wr;
  logic          odd;
  logic [WA-1:0] waddr;
  logic          dl_q;
  logic          dl_rise;
  logic          dl_fall;

  logic          pend;
  logic [WA-1:0] pend_addr;
  logic [7:0]    pend_data;
  logic          odd_q;
  word_t         odd_word;
  logic          push_q;
  word_t         push_word;
  word_t         lo_word;
  word_t         hi_word;

  word_t         head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          load;
  state_t        state_q;
  state_t        state_d;

  assign rom_wr  = ioctl_wr & ~ioctl_cheat & ~ioctl_ram;
  assign odd     = ioctl_addr[0];
  assign waddr   = ioctl_addr[AW-1:1];
  assign dl_rise = downloading & ~dl_q;
  assign dl_fall = ~downloading & dl_q;
  assign lo_word = {pend_addr, 8'h00, pend_data, MASK_LO};
  assign hi_word = {waddr, ioctl_dout, 8'h00, MASK_HI};

  // cheat/NVRAM bytes bypass the packer, one cycle late
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cheat_we   <= 1'b0;
      cheat_addr <= '0;
      cheat_din  <= '0;
      nvram_we   <= 1'b0;
      nvram_addr <= '0;
      nvram_din  <= '0;
    end else begin
      cheat_we <= ioctl_wr & ioctl_cheat;
      nvram_we <= ioctl_wr & ~ioctl_cheat & ioctl_ram;
      if (ioctl_wr & ioctl_cheat) begin
        cheat_addr <= ioctl_addr[7:0];
        cheat_din  <= ioctl_dout;
      end
      if (ioctl_wr & ~ioctl_cheat & ioctl_ram) begin
        nvram_addr <= ioctl_addr[NVAW-1:0];
        nvram_din  <= ioctl_dout;
      end
    end
  end

  // byte packer; a split word pushes its second half next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      odd_q     <= 1'b0;
      odd_word  <= '0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      push_q <= 1'b0;
      odd_q  <= 1'b0;
      if (dl_rise) pend <= 1'b0;
      if (odd_q) begin
        push_q    <= 1'b1;
        push_word <= odd_word;
      end else if (rom_wr && !odd) begin
        if (pend) begin
          push_q    <= 1'b1;
          push_word <= lo_word;
        end
        pend      <= 1'b1;
        pend_addr <= waddr;
        pend_data <= ioctl_dout;
      end else if (rom_wr) begin
        pend   <= 1'b0;
        push_q <= 1'b1;
        if (pend && pend_addr == waddr) begin
          push_word <= {waddr, ioctl_dout, pend_data, MASK_FULL};
        end else if (pend) begin
          push_word <= lo_word;
          odd_q     <= 1'b1;
          odd_word  <= hi_word;
        end else begin
          push_word <= hi_word;
        end
      end else if (dl_fall && pend) begin
        pend      <= 1'b0;
        push_q    <= 1'b1;
        push_word <= lo_word;
      end
    end
  end

  // edge detect and sticky drop flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_q     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (dl_rise) overflow <= 1'b0;
      else if (push_q & full & ~pop) overflow <= 1'b1;
    end
  end

  jtframe_dwnld_fifo #(
    .W       (W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (pop),
    .din   (push_word),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // issue FSM next state
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = REQ;
          load    = 1'b1;
        end
      end
      REQ: begin
        if (prog.prog_rdy) begin
          state_d = GAP;
          pop     = 1'b1;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // issue FSM state and request register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      prog.prog_addr <= '0;
      prog.prog_data <= '0;
      prog.prog_mask <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        prog.prog_addr <= head.addr;
        prog.prog_data <= head.data;
        prog.prog_mask <= head.mask;
      end
    end
  end

  assign prog.prog_we = state_q == REQ;

  assign busy = downloading | pend | odd_q | push_q |
                ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_jtframe_dwnld_sched.sv
// Bench for jtframe_dwnld_sched: scenario tasks plus a
// scoreboard checked whenever a new SDRAM request appears.
module tb_jtframe_dwnld_sched;
  import jtframe_dwnld_pkg::*;

  localparam int AW   = 25;
  localparam int NVAW = 16;

  typedef struct {
    logic [AW-2:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            downloading = 1'b0;
  logic [AW-1:0]   ioctl_addr = '0;
  logic [7:0]      ioctl_dout = '0;
  logic            ioctl_wr = 1'b0;
  logic            ioctl_ram = 1'b0;
  logic            ioctl_cheat = 1'b0;
  logic            cheat_we;
  logic [7:0]      cheat_addr;
  logic [7:0]      cheat_din;
  logic            nvram_we;
  logic [NVAW-1:0] nvram_addr;
  logic [7:0]      nvram_din;
  logic            busy;
  logic            overflow;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic we_d = 1'b0;
  logic [15:0] got_m;
  logic [15:0] exp_m;

  jtframe_dwnld_if #(.AW(AW)) prog();

  jtframe_dwnld_sched #(
    .AW      (AW),
    .FIFO_AW (2),
    .NVAW    (NVAW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .ioctl_ram   (ioctl_ram),
    .ioctl_cheat (ioctl_cheat),
    .prog        (prog),
    .cheat_we    (cheat_we),
    .cheat_addr  (cheat_addr),
    .cheat_din   (cheat_din),
    .nvram_we    (nvram_we),
    .nvram_addr  (nvram_addr),
    .nvram_din   (nvram_din),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // scoreboard: every new request must match the oldest expectation
  always @(negedge clk) begin
    if (prog.prog_we && !we_d) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected addr=%h data=%h mask=%b",
                 prog.prog_addr, prog.prog_data, prog.prog_mask);
      end else begin
        mon_e = sb.pop_front();
        got_m = prog.prog_data;
        exp_m = mon_e.data;
        if (mon_e.mask[0]) begin
          got_m[7:0] = 8'h00;
          exp_m[7:0] = 8'h00;
        end
        if (mon_e.mask[1]) begin
          got_m[15:8] = 8'h00;
          exp_m[15:8] = 8'h00;
        end
        if ({prog.prog_addr, prog.prog_mask, got_m} !==
            {mon_e.addr, mon_e.mask, exp_m}) begin
          errors++;
          $display("FAIL sb_word got=%h/%h/%b exp=%h/%h/%b",
                   prog.prog_addr, prog.prog_data, prog.prog_mask,
                   mon_e.addr, mon_e.data, mon_e.mask);
        end
      end
    end
    we_d = prog.prog_we;
  end

  task automatic wr_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack_one(input int dly, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !prog.prog_we; i++) @(negedge clk);
    if (!prog.prog_we) return;
    repeat (dly) @(negedge clk);
    prog.prog_rdy = 1'b1;
    @(negedge clk);
    prog.prog_rdy = 1'b0;
    ok = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    ok = !busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (prog.prog_we !== 1'b0) begin
      errors++; $display("FAIL rst_we got=%b exp=0", prog.prog_we);
    end
    checks++;
    if ({prog.prog_addr, prog.prog_data, prog.prog_mask} !== '0) begin
      errors++; $display("FAIL rst_bus got=%h/%h/%b exp=0",
        prog.prog_addr, prog.prog_data, prog.prog_mask);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_busy got=%b exp=0", busy);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL rst_ovf got=%b exp=0", overflow);
    end
    checks++;
    if ({cheat_we, nvram_we} !== 2'b00) begin
      errors++; $display("FAIL rst_side_we got=%b exp=00",
        {cheat_we, nvram_we});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word;
    downloading = 1'b1;
    @(negedge clk);
    wr_byte(25'd0, 8'h11);
    sb.push_back('{24'd0, 16'h2211, MASK_FULL});
    wr_byte(25'd1, 8'h22);
    checks++;
    if (prog.prog_we !== 1'b0) begin
      errors++; $display("FAIL word_we_early got=%b exp=0", prog.prog_we);
    end
    @(negedge clk);
    checks++;
    if (prog.prog_we !== 1'b1) begin
      errors++; $display("FAIL word_we_n2 got=%b exp=1", prog.prog_we);
    end
    downloading = 1'b0;
    repeat (2) @(negedge clk);
    prog.prog_rdy = 1'b1;
    @(negedge clk);
    prog.prog_rdy = 1'b0;
    checks++;
    if ({prog.prog_we, busy} !== 2'b01) begin
      errors++; $display("FAIL word_gap we/busy got=%b exp=01",
        {prog.prog_we, busy});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL word_busy_end got=%b exp=0", busy);
    end
  endtask

  task automatic test_flush;
    bit ok;
    downloading = 1'b1;
    @(negedge clk);
    sb.push_back('{24'd2, 16'h0033, MASK_LO});
    wr_byte(25'd4, 8'h33);
    downloading = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (prog.prog_we !== 1'b0) begin
      errors++; $display("FAIL flush_we_early got=%b exp=0", prog.prog_we);
    end
    @(negedge clk);
    checks++;
    if (prog.prog_we !== 1'b1) begin
      errors++; $display("FAIL flush_we got=%b exp=1", prog.prog_we);
    end
    ack_one(1, ok);
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL flush_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_hi;
    bit ok;
    downloading = 1'b1;
    @(negedge clk);
    sb.push_back('{24'd3, 16'h4400, MASK_HI});
    wr_byte(25'd7, 8'h44);
    downloading = 1'b0;
    ack_one(0, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL hi_timeout we=%b exp=1", prog.prog_we);
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL hi_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_split;
    bit ok;
    int acks = 0;
    downloading = 1'b1;
    @(negedge clk);
    sb.push_back('{24'd4, 16'h0055, MASK_LO});
    sb.push_back('{24'd5, 16'h6600, MASK_HI});
    wr_byte(25'd8, 8'h55);
    wr_byte(25'd11, 8'h66);
    sb.push_back('{24'd6, 16'h0077, MASK_LO});
    wr_byte(25'd12, 8'h77);
    sb.push_back('{24'd7, 16'h0088, MASK_LO});
    wr_byte(25'd14, 8'h88);
    downloading = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ack_one(1, ok);
      if (ok) acks++;
    end
    checks++;
    if (acks !== 4) begin
      errors++; $display("FAIL split_acks got=%0d exp=4", acks);
    end
    wait_idle(ok);
    checks++;
    if ({ok, overflow} !== 2'b10) begin
      errors++; $display("FAIL split_end idle/ovf got=%b exp=10",
        {ok, overflow});
    end
  endtask

  task automatic test_overflow;
    bit ok;
    int acks = 0;
    logic [7:0] b;
    logic [7:0] p;
    downloading = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      b = 8'hC0 + 8'(i);
      p = b - 8'd1;
      if ((i % 2) == 1 && (i / 2) < 4)
        sb.push_back('{24'(16 + i / 2), {b, p}, MASK_FULL});
      wr_byte(25'(32 + i), b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set got=%b exp=1", overflow);
    end
    downloading = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ack_one(0, ok);
      if (ok) acks++;
    end
    checks++;
    if (acks !== 4) begin
      errors++; $display("FAIL ovf_acks got=%0d exp=4", acks);
    end
    wait_idle(ok);
    checks++;
    if ({ok, overflow} !== 2'b11) begin
      errors++; $display("FAIL ovf_sticky idle/ovf got=%b exp=11",
        {ok, overflow});
    end
    downloading = 1'b1;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got=%b exp=0", overflow);
    end
    downloading = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cheat;
    ioctl_cheat = 1'b1;
    ioctl_ram   = 1'b1;
    ioctl_addr  = 25'h13;
    ioctl_dout  = 8'hA5;
    ioctl_wr    = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    checks++;
    if ({cheat_we, nvram_we, cheat_addr, cheat_din} !== {2'b10, 16'h13A5}) begin
      errors++; $display("FAIL cheat_port got=%b%b/%h/%h exp=10/13/a5",
        cheat_we, nvram_we, cheat_addr, cheat_din);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL cheat_nofifo busy=%b exp=0", busy);
    end
    @(negedge clk);
    checks++;
    if ({cheat_we, busy, prog.prog_we} !== 3'b000) begin
      errors++; $display("FAIL cheat_pulse we/busy/pwe got=%b exp=000",
        {cheat_we, busy, prog.prog_we});
    end
    ioctl_cheat = 1'b0;
    ioctl_addr  = 25'h1ABCDEF;
    ioctl_dout  = 8'h5A;
    ioctl_wr    = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    checks++;
    if ({nvram_we, cheat_we, nvram_addr, nvram_din} !== {2'b10, 24'hCDEF5A}) begin
      errors++; $display("FAIL nvram_port got=%b%b/%h/%h exp=10/cdef/5a",
        nvram_we, cheat_we, nvram_addr, nvram_din);
    end
    @(negedge clk);
    checks++;
    if ({nvram_we, busy} !== 2'b00) begin
      errors++; $display("FAIL nvram_pulse we/busy got=%b exp=00",
        {nvram_we, busy});
    end
    ioctl_ram = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    downloading = 1'b1;
    @(negedge clk);
    sb.push_back('{24'd20, 16'hAA99, MASK_FULL});
    wr_byte(25'd40, 8'h99);
    wr_byte(25'd41, 8'hAA);
    wr_byte(25'd42, 8'hBB);
    wr_byte(25'd43, 8'hCC);
    downloading = 1'b0;
    for (int i = 0; i < 10 && !prog.prog_we; i++) @(negedge clk);
    checks++;
    if (prog.prog_we !== 1'b1) begin
      errors++; $display("FAIL rmid_req got=%b exp=1", prog.prog_we);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({prog.prog_we, busy} !== 2'b00) begin
      errors++; $display("FAIL rmid_drop we/busy got=%b exp=00",
        {prog.prog_we, busy});
    end
    rst_n = 1'b1;
    @(negedge clk);
    prog.prog_rdy = 1'b1;
    @(negedge clk);
    prog.prog_rdy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (prog.prog_we || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rmid_stale got=1 exp=0");
    end
  endtask

  initial begin
    prog.prog_rdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_word();
    test_flush();
    test_hi();
    test_split();
    test_overflow();
    test_cheat();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
